fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Sequencing controller for the instruction-fetch stage of the 32-bit MIPS/RISC-style pipeline. Drives the IF stage's `pc_ctrl` (PC write enable), `pc_mux_ctrl` (branch-target select) and `beq_address`, plus the IF/ID write/flush and ID/EX bubble controls. It arbitrates between normal sequential fetch, load-use stalls, taken-branch redirects with wrong-path flushing, and debug halt/resume. It also holds the pipeline idle for a fixed number of cycles after reset.

## Interface

Parameters:
- `RESET_HOLD` default 2: cycles held in INIT after reset release; must be ≥1.
- `FLUSH_SLOTS` default 2: wrong-path slots flushed per taken branch; must be ≥1.
- `MAX_STALL` default 4: consecutive load-use stall cycles that trip `stall_timeout`; must be ≥1.

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `load_use_hazard` in 1: from hazard detect; ID instruction depends on load in EX.
- `branch_taken` in 1: 1-cycle pulse from EX; beq resolved taken.
- `branch_target` in 32: target address; valid when `branch_taken`=1.
- `halt_req` in 1: level; request fetch halt.
- `resume` in 1: pulse; leave HALT.
- `pc_ctrl` out 1: PC write enable to IF stage.
- `pc_mux_ctrl` out 1: 1 selects `beq_address`; 0 selects PC+4.
- `beq_address` out 32: registered branch target to IF stage.
- `ifid_write` out 1: IF/ID register write enable.
- `ifid_flush` out 1: IF/ID register loads NOP.
- `idex_bubble` out 1: ID/EX register loads NOP.
- `stall_timeout` out 1: sticky error flag.
- `fetch_state` out 3: current state code.

## Operation

- States and codes: INIT=0, RUN=1, REDIRECT=2, FLUSH=3, HALT=4. Codes 5–7 are unreachable and recover to INIT on the next edge.
- INIT outputs: `pc_ctrl`=0, `pc_mux_ctrl`=0, `ifid_write`=0, `ifid_flush`=1, `idex_bubble`=1. Stays RESET_HOLD cycles, then goes to RUN. All inputs are ignored in INIT.
- RUN, per-cycle priority (Mealy outputs):
  - `branch_taken`=1: latch `branch_target` into `beq_address`; next state REDIRECT. Outputs this cycle are `pc_ctrl`=1, `ifid_write`=1, `idex_bubble`=0. The load-use hazard is ignored because that instruction is wrong-path.
  - Else `halt_req`=1: next state HALT. Outputs as normal fetch this cycle.
  - Else `load_use_hazard`=1 (stall): `pc_ctrl`=0, `ifid_write`=0, `idex_bubble`=1. Stall counter increments, saturating at MAX_STALL. On reaching MAX_STALL, set `stall_timeout` (sticky until `rst`). The stall continues while the hazard is held.
  - Else normal fetch: `pc_ctrl`=1, `ifid_write`=1, `pc_mux_ctrl`=0, `ifid_flush`=0, `idex_bubble`=0. Stall counter clears.
- REDIRECT (1 cycle): `pc_ctrl`=1, `pc_mux_ctrl`=1, `ifid_write`=1, `ifid_flush`=1, `idex_bubble`=1.
  - If FLUSH_SLOTS=1, next state is RUN; otherwise FLUSH with counter = FLUSH_SLOTS−1.
- FLUSH: `pc_ctrl`=1, `pc_mux_ctrl`=0, `ifid_write`=1, `ifid_flush`=1, `idex_bubble`=0. Counter decrements; go to RUN when it reaches 0.
  - `branch_taken`, `halt_req` and `load_use_hazard` are ignored in REDIRECT and FLUSH, since they come from the flushed path.
- HALT: `pc_ctrl`=0, `ifid_write`=0, `ifid_flush`=1, `idex_bubble`=1. `resume`=1 returns to RUN next cycle, even if `halt_req` is still high. In that case RUN re-enters HALT one cycle later.
- `beq_address` changes only on a RUN-state `branch_taken` capture or on reset.

## Timing

- Reset (`rst` sampled 1 at an edge) sets, from the next cycle: state INIT, `fetch_state`=0, `beq_address`=0, counters 0, `stall_timeout`=0. Outputs take INIT values.
- `rst` overrides everything, including mid-REDIRECT, mid-FLUSH and HALT. The latched target is discarded.
- With `rst` deasserted at edge E0: INIT covers cycles E0..E0+RESET_HOLD−1, and the first `pc_ctrl`=1 is at cycle E0+RESET_HOLD.
- Branch latency: `branch_taken` in cycle T, REDIRECT in T+1 (PC loads target at the end of T+1), FLUSH in T+2..T+FLUSH_SLOTS, RUN resumes at T+FLUSH_SLOTS+1.
- Stall response is combinational in the same cycle as `load_use_hazard`. Zero added latency.
- The timeout asserts in the cycle after the MAX_STALL-th consecutive stall cycle.

## Test plan

- Reset/INIT: `rst`=1 for 2 cycles, then 0 with defaults -> `pc_ctrl`=0, `ifid_flush`=1 for 2 cycles; `fetch_state`=1 and `pc_ctrl`=1 on the 3rd cycle; `beq_address`=0.
- Branch: `branch_taken`=1, `branch_target`=9 for 1 cycle -> next cycle `pc_mux_ctrl`=1, `beq_address`=9, `ifid_flush`=1; one FLUSH cycle with `pc_mux_ctrl`=0; then RUN.
- Stall/timeout: `load_use_hazard`=1 for 5 cycles -> `pc_ctrl`=0, `idex_bubble`=1 each cycle; `stall_timeout`=1 from the 5th cycle and held after the hazard drops.
- Simultaneous events: `branch_taken`=1 (target 12), `load_use_hazard`=1 and `halt_req`=1 in the same cycle -> `pc_ctrl`=1, `idex_bubble`=0, then REDIRECT to 12. HALT is entered only after FLUSH completes.
- Halt/resume: `halt_req`=1 in RUN -> HALT (`fetch_state`=4, `pc_ctrl`=0). Drop `halt_req` and pulse `resume` -> RUN next cycle with `pc_ctrl`=1.
- Reset mid-FLUSH (`FLUSH_SLOTS`=3): assert `rst` in the first FLUSH cycle -> INIT next cycle, `beq_address`=0, no further `pc_mux_ctrl`=1.

Source files
------------

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: IF-stage sequencing controller. Arbitrates sequential fetch,
// load-use stalls, taken-branch redirect + wrong-path flush, debug halt,
// and a fixed idle window after reset.
module fetch_ctrl #(
    parameter int RESET_HOLD  = 2,
    parameter int FLUSH_SLOTS = 2,
    parameter int MAX_STALL   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_use_hazard,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        halt_req,
    input  logic        resume,
    output logic        pc_ctrl,
    output logic        pc_mux_ctrl,
    output logic [31:0] beq_address,
    output logic        ifid_write,
    output logic        ifid_flush,
    output logic        idex_bubble,
    output logic        stall_timeout,
    output logic [2:0]  fetch_state
);

    typedef enum logic [2:0] {
        S_INIT     = 3'd0,
        S_RUN      = 3'd1,
        S_REDIRECT = 3'd2,
        S_FLUSH    = 3'd3,
        S_HALT     = 3'd4
    } state_e;

    localparam int IW = (RESET_HOLD  < 1) ? 1 : $clog2(RESET_HOLD + 1);
    localparam int FW = (FLUSH_SLOTS < 1) ? 1 : $clog2(FLUSH_SLOTS + 1);
    localparam int SW = (MAX_STALL   < 1) ? 1 : $clog2(MAX_STALL + 1);

    localparam logic [IW-1:0] INIT_LAST  = IW'(RESET_HOLD - 1);
    localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_SLOTS - 1);
    localparam logic [SW-1:0] STALL_LAST = SW'(MAX_STALL - 1);
    localparam logic [SW-1:0] STALL_SAT  = SW'(MAX_STALL);

    state_e        state_q, state_d;
    logic [IW-1:0] init_cnt_q, init_cnt_d;
    logic [FW-1:0] flush_cnt_q, flush_cnt_d;
    logic [SW-1:0] stall_cnt_q, stall_cnt_d;
    logic          timeout_q, timeout_d;
    logic [31:0]   beq_q, beq_d;

    // Next-state and Mealy outputs; RUN reacts to hazards in the same cycle.
    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        flush_cnt_d = flush_cnt_q;
        stall_cnt_d = stall_cnt_q;
        timeout_d   = timeout_q;
        beq_d       = beq_q;
        pc_ctrl     = 1'b0;
        pc_mux_ctrl = 1'b0;
        ifid_write  = 1'b0;
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
        case (state_q)
            S_INIT: begin
                if (init_cnt_q == INIT_LAST) begin
                    state_d    = S_RUN;
                    init_cnt_d = '0;
                end else begin
                    init_cnt_d = init_cnt_q + 1'b1;
                end
            end
            S_RUN: begin
                pc_ctrl     = 1'b1;
                ifid_write  = 1'b1;
                ifid_flush  = 1'b0;
                idex_bubble = 1'b0;
                if (branch_taken) begin
                    // Hazard here belongs to a wrong-path instruction: no stall.
                    beq_d       = branch_target;
                    state_d     = S_REDIRECT;
                    stall_cnt_d = '0;
                end else if (halt_req) begin
                    state_d     = S_HALT;
                    stall_cnt_d = '0;
                end else if (load_use_hazard) begin
                    pc_ctrl     = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                    if (stall_cnt_q != STALL_SAT)
                        stall_cnt_d = stall_cnt_q + 1'b1;
                    if (stall_cnt_q == STALL_LAST)
                        timeout_d = 1'b1;
                end else begin
                    stall_cnt_d = '0;
                end
            end
            S_REDIRECT: begin
                pc_ctrl     = 1'b1;
                pc_mux_ctrl = 1'b1;
                ifid_write  = 1'b1;
                if (FLUSH_SLOTS == 1) begin
                    state_d = S_RUN;
                end else begin
                    state_d     = S_FLUSH;
                    flush_cnt_d = FLUSH_LAST;
                end
            end
            S_FLUSH: begin
                pc_ctrl     = 1'b1;
                ifid_write  = 1'b1;
                idex_bubble = 1'b0;
                if (flush_cnt_q <= FW'(1)) begin
                    state_d     = S_RUN;
                    flush_cnt_d = '0;
                end else begin
                    flush_cnt_d = flush_cnt_q - 1'b1;
                end
            end
            S_HALT: begin
                if (resume)
                    state_d = S_RUN;
            end
            default: begin
                // Illegal encodings fall back to the reset idle window.
                state_d    = S_INIT;
                init_cnt_d = '0;
            end
        endcase
    end

    // State, counters, sticky timeout and latched branch target.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_INIT;
            init_cnt_q  <= '0;
            flush_cnt_q <= '0;
            stall_cnt_q <= '0;
            timeout_q   <= 1'b0;
            beq_q       <= '0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            timeout_q   <= timeout_d;
            beq_q       <= beq_d;
        end
    end

    assign beq_address   = beq_q;
    assign stall_timeout = timeout_q;
    assign fetch_state   = state_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: one-cycle vector table on a default
// instance, plus a reset-mid-FLUSH sequence on a FLUSH_SLOTS=3 instance.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst, lu, bt, hr, rs;
    logic [31:0] tg;

    logic        a_pc, a_mx, a_ifw, a_fl, a_bb, a_to;
    logic [31:0] a_beq;
    logic [2:0]  a_st;
    logic        b_pc, b_mx, b_ifw, b_fl, b_bb, b_to;
    logic [31:0] b_beq;
    logic [2:0]  b_st;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fetch_ctrl dut_a (
        .clk(clk), .rst(rst), .load_use_hazard(lu), .branch_taken(bt),
        .branch_target(tg), .halt_req(hr), .resume(rs),
        .pc_ctrl(a_pc), .pc_mux_ctrl(a_mx), .beq_address(a_beq),
        .ifid_write(a_ifw), .ifid_flush(a_fl), .idex_bubble(a_bb),
        .stall_timeout(a_to), .fetch_state(a_st)
    );

    fetch_ctrl #(.RESET_HOLD(2), .FLUSH_SLOTS(3), .MAX_STALL(4)) dut_b (
        .clk(clk), .rst(rst), .load_use_hazard(lu), .branch_taken(bt),
        .branch_target(tg), .halt_req(hr), .resume(rs),
        .pc_ctrl(b_pc), .pc_mux_ctrl(b_mx), .beq_address(b_beq),
        .ifid_write(b_ifw), .ifid_flush(b_fl), .idex_bubble(b_bb),
        .stall_timeout(b_to), .fetch_state(b_st)
    );

    // control bundle order: pc_ctrl, pc_mux_ctrl, ifid_write, ifid_flush, idex_bubble
    localparam logic [4:0] C_IDLE  = 5'b00011;  // INIT and HALT
    localparam logic [4:0] C_FETCH = 5'b10100;
    localparam logic [4:0] C_STALL = 5'b00001;
    localparam logic [4:0] C_REDIR = 5'b11111;
    localparam logic [4:0] C_FLUSH = 5'b10110;

    typedef struct {
        logic        r, lu, bt;
        logic [31:0] tg;
        logic        hr, rs;
        logic [4:0]  ctl;
        logic        to;
        logic [2:0]  st;
        logic [31:0] beq;
    } vec_t;

    function automatic vec_t mk(logic r, logic l, logic b, logic [31:0] t,
                                logic h, logic s, logic [4:0] c, logic o,
                                logic [2:0] st, logic [31:0] q);
        vec_t v;
        v.r = r; v.lu = l; v.bt = b; v.tg = t; v.hr = h; v.rs = s;
        v.ctl = c; v.to = o; v.st = st; v.beq = q;
        return v;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic drive(logic r, logic l, logic b, logic [31:0] t, logic h, logic s);
        rst = r; lu = l; bt = b; tg = t; hr = h; rs = s;
    endtask

    vec_t v[31];

    initial begin
        //        r  lu bt tg     hr rs  ctl      to st  beq
        v[0]  = mk(0, 0, 0, 0,     0, 0, C_IDLE,  0, 0, 0);
        v[1]  = mk(0, 0, 1, 77,    1, 0, C_IDLE,  0, 0, 0);   // inputs ignored in INIT
        v[2]  = mk(0, 0, 0, 0,     0, 0, C_FETCH, 0, 1, 0);
        v[3]  = mk(0, 0, 1, 9,     0, 0, C_FETCH, 0, 1, 0);   // branch to 9
        v[4]  = mk(0, 0, 0, 0,     0, 0, C_REDIR, 0, 2, 9);
        v[5]  = mk(0, 0, 0, 0,     0, 0, C_FLUSH, 0, 3, 9);
        v[6]  = mk(0, 0, 0, 0,     0, 0, C_FETCH, 0, 1, 9);
        v[7]  = mk(0, 1, 0, 0,     0, 0, C_STALL, 0, 1, 9);   // 5 stall cycles
        v[8]  = mk(0, 1, 0, 0,     0, 0, C_STALL, 0, 1, 9);
        v[9]  = mk(0, 1, 0, 0,     0, 0, C_STALL, 0, 1, 9);
        v[10] = mk(0, 1, 0, 0,     0, 0, C_STALL, 0, 1, 9);
        v[11] = mk(0, 1, 0, 0,     0, 0, C_STALL, 1, 1, 9);
        v[12] = mk(0, 0, 0, 0,     0, 0, C_FETCH, 1, 1, 9);   // timeout sticky
        v[13] = mk(0, 1, 1, 12,    1, 0, C_FETCH, 1, 1, 9);   // branch beats all
        v[14] = mk(0, 1, 0, 0,     1, 0, C_REDIR, 1, 2, 12);
        v[15] = mk(0, 1, 1, 55,    1, 0, C_FLUSH, 1, 3, 12);  // flushed-path inputs
        v[16] = mk(0, 0, 0, 0,     1, 0, C_FETCH, 1, 1, 12);
        v[17] = mk(0, 0, 0, 0,     1, 0, C_IDLE,  1, 4, 12);
        v[18] = mk(0, 0, 0, 0,     0, 0, C_IDLE,  1, 4, 12);
        v[19] = mk(0, 0, 0, 0,     0, 1, C_IDLE,  1, 4, 12);
        v[20] = mk(0, 0, 0, 0,     0, 0, C_FETCH, 1, 1, 12);
        v[21] = mk(0, 0, 0, 0,     1, 0, C_FETCH, 1, 1, 12);
        v[22] = mk(0, 0, 0, 0,     1, 1, C_IDLE,  1, 4, 12);  // resume with halt held
        v[23] = mk(0, 0, 0, 0,     1, 0, C_FETCH, 1, 1, 12);
        v[24] = mk(0, 0, 0, 0,     0, 0, C_IDLE,  1, 4, 12);
        v[25] = mk(0, 0, 0, 0,     0, 1, C_IDLE,  1, 4, 12);
        v[26] = mk(0, 0, 0, 0,     0, 0, C_FETCH, 1, 1, 12);
        v[27] = mk(1, 0, 0, 0,     0, 0, C_FETCH, 1, 1, 12);  // reset from RUN
        v[28] = mk(0, 0, 0, 0,     0, 0, C_IDLE,  0, 0, 0);
        v[29] = mk(0, 0, 0, 0,     0, 0, C_IDLE,  0, 0, 0);
        v[30] = mk(0, 0, 0, 0,     0, 0, C_FETCH, 0, 1, 0);

        drive(1, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("reset_state", {23'd0, a_pc, a_mx, a_ifw, a_fl, a_bb, a_to, a_st, a_beq},
            {23'd0, C_IDLE, 1'b0, 3'd0, 32'd0});
        @(posedge clk); #1;

        for (int i = 0; i < 31; i++) begin
            drive(v[i].r, v[i].lu, v[i].bt, v[i].tg, v[i].hr, v[i].rs);
            @(negedge clk);
            chk($sformatf("vec%0d", i),
                {23'd0, a_pc, a_mx, a_ifw, a_fl, a_bb, a_to, a_st, a_beq},
                {23'd0, v[i].ctl, v[i].to, v[i].st, v[i].beq});
            @(posedge clk); #1;
        end

        // Reset in the first FLUSH cycle of the 3-slot instance.
        drive(0, 0, 1, 32'h1234, 0, 0);
        @(negedge clk); chk("b_run", {61'd0, b_st}, 64'd1);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk); chk("b_redirect", {28'd0, b_mx, b_st, b_beq}, {28'd0, 1'b1, 3'd2, 32'h1234});
        @(posedge clk); #1;
        drive(1, 0, 0, 0, 0, 0);
        @(negedge clk); chk("b_flush", {60'd0, b_mx, b_st}, {60'd0, 1'b0, 3'd3});
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("b_after_rst", {27'd0, b_pc, b_mx, b_st, b_beq}, {27'd0, 1'b0, 1'b0, 3'd0, 32'd0});
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk($sformatf("b_nomux%0d", k), {63'd0, b_mx}, 64'd0);
            if (k == 1)
                chk("b_run_again", {28'd0, b_pc, b_st, b_beq}, {28'd0, 1'b1, 3'd1, 32'd0});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
